// File: rtl/controlador_operacoes.sv
// Command scheduler for the four resizing engines: command FIFO, validation, start/done sequencing.
// Optional watchdog in WAIT is enabled by defining CTRL_TIMEOUT_EN.
module controlador_operacoes #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1048575,
    parameter int unsigned W_ORIG         = 160,
    parameter int unsigned H_ORIG         = 120,
    parameter int unsigned SCR_W          = 640,
    parameter int unsigned SCR_H          = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_alg,
    input  logic [1:0] cmd_zoom,
    output logic       cmd_ready,
    input  logic [3:0] done_i,
    output logic [3:0] start_o,
    output logic [1:0] sel_o,
    output logic [1:0] zoom_o,
    output logic [9:0] img_w_o,
    output logic [9:0] img_h_o,
    output logic [9:0] x_off_o,
    output logic [9:0] y_off_o,
    output logic       exibe_o,
    output logic       busy_o,
    output logic       fin_o,
    output logic       abort_o,
    output logic [1:0] err_o,
    output logic [2:0] fifo_count_o
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
    localparam logic [9:0] W0     = 10'(W_ORIG);
    localparam logic [9:0] H0     = 10'(H_ORIG);
    localparam logic [9:0] SW     = 10'(SCR_W);
    localparam logic [9:0] SH     = 10'(SCR_H);
    localparam logic [9:0] X0     = 10'((SCR_W - W_ORIG) / 2);
    localparam logic [9:0] Y0     = 10'((SCR_H - H_ORIG) / 2);

    typedef enum logic [1:0] {StIdle, StCheck, StIssue, StWait} state_t;

    state_t      state;
    logic [3:0]  fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic        push, pop;
    logic [1:0]  cur_alg, cur_zoom;
    logic [3:0]  done_q;
    logic        done_rise, invalid;
    logic [9:0]  geo_w, geo_h;

    assign cmd_ready    = (count < CNT_FULL);
    assign push         = cmd_valid & cmd_ready;
    assign pop          = (state == StIdle) && (count != '0);
    assign fifo_count_o = 3'(count);
    assign busy_o       = (state != StIdle);
    assign done_rise    = done_i[sel_o] & ~done_q[sel_o];
    // 1280x960 does not fit on screen
    assign invalid      = ~cur_alg[0] & (cur_zoom == 2'b11);

    always_comb begin
        geo_w = W0;
        geo_h = H0;
        if (!cur_alg[0]) begin
            geo_w = W0 << cur_zoom;
            geo_h = H0 << cur_zoom;
        end else begin
            geo_w = W0 >> cur_zoom;
            geo_h = H0 >> cur_zoom;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {cmd_alg, cmd_zoom};
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        done_q <= done_i;
    end

`ifdef CTRL_TIMEOUT_EN
    logic [19:0] to_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign abort_o        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            cur_alg  <= 2'b00;
            cur_zoom <= 2'b00;
            start_o  <= 4'b0000;
            sel_o    <= 2'b00;
            zoom_o   <= 2'b00;
            img_w_o  <= W0;
            img_h_o  <= H0;
            x_off_o  <= X0;
            y_off_o  <= Y0;
            exibe_o  <= 1'b0;
            fin_o    <= 1'b0;
            err_o    <= 2'b00;
`ifdef CTRL_TIMEOUT_EN
            abort_o  <= 1'b0;
            to_cnt   <= '0;
`endif
        end else begin
            start_o <= 4'b0000;
            fin_o   <= 1'b0;
`ifdef CTRL_TIMEOUT_EN
            abort_o <= 1'b0;
`endif
            unique case (state)
                StIdle: begin
                    if (pop) begin
                        {cur_alg, cur_zoom} <= fifo_mem[rd_ptr];
                        state               <= StCheck;
                    end
                end
                StCheck: begin
                    if (invalid) begin
                        err_o <= 2'b01;
                        fin_o <= 1'b1;
                        state <= StIdle;
                    end else begin
                        start_o <= 4'b0001 << cur_alg;
                        sel_o   <= cur_alg;
                        zoom_o  <= cur_zoom;
                        img_w_o <= geo_w;
                        img_h_o <= geo_h;
                        x_off_o <= (SW - geo_w) >> 1;
                        y_off_o <= (SH - geo_h) >> 1;
                        exibe_o <= 1'b0;
                        err_o   <= 2'b00;
                        state   <= StIssue;
                    end
                end
                StIssue: begin
`ifdef CTRL_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                    state <= StWait;
                end
                StWait: begin
                    if (done_rise) begin
                        exibe_o <= 1'b1;
                        fin_o   <= 1'b1;
                        state   <= StIdle;
`ifdef CTRL_TIMEOUT_EN
                    end else if (to_cnt == 20'(TIMEOUT_CYCLES - 1)) begin
                        abort_o <= 1'b1;
                        err_o   <= 2'b10;
                        state   <= StIdle;
                    end else begin
                        to_cnt <= to_cnt + 20'd1;
`endif
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_operacoes.sv
// Directed bench for controlador_operacoes: reset, latency, vector table, stale done, full FIFO,
// watchdog (when CTRL_TIMEOUT_EN is defined) and reset in the middle of a run.
module tb_controlador_operacoes;

    logic       clk = 1'b0;
    logic       rst, cmd_valid, cmd_ready;
    logic [1:0] cmd_alg, cmd_zoom;
    logic [3:0] done_i, start_o;
    logic [1:0] sel_o, zoom_o, err_o;
    logic [9:0] img_w_o, img_h_o, x_off_o, y_off_o;
    logic       exibe_o, busy_o, fin_o, abort_o;
    logic [2:0] fifo_count_o;

    int checks = 0;
    int errors = 0;
    logic [3:0] start_log[$];

    always #5 clk = ~clk;

    controlador_operacoes #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_alg(cmd_alg), .cmd_zoom(cmd_zoom),
        .cmd_ready(cmd_ready), .done_i(done_i), .start_o(start_o), .sel_o(sel_o),
        .zoom_o(zoom_o), .img_w_o(img_w_o), .img_h_o(img_h_o), .x_off_o(x_off_o),
        .y_off_o(y_off_o), .exibe_o(exibe_o), .busy_o(busy_o), .fin_o(fin_o),
        .abort_o(abort_o), .err_o(err_o), .fifo_count_o(fifo_count_o)
    );

    always @(negedge clk) if (start_o != 4'b0000) start_log.push_back(start_o);

    typedef struct {
        logic [1:0] alg;
        logic [1:0] zoom;
        bit         valid;
        int         w, h, x, y;
    } vec_t;

    vec_t vecs[12];
    int exp_w = 160, exp_h = 120, exp_x = 240, exp_y = 180;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_geo(input string nm, input int w, input int h, input int x, input int y);
        chk({nm, "_w"}, 32'(img_w_o), w);
        chk({nm, "_h"}, 32'(img_h_o), h);
        chk({nm, "_x"}, 32'(x_off_o), x);
        chk({nm, "_y"}, 32'(y_off_o), y);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_start"}, 32'(start_o), 0);
        chk({nm, "_sel"}, 32'(sel_o), 0);
        chk({nm, "_zoom"}, 32'(zoom_o), 0);
        chk_geo(nm, 160, 120, 240, 180);
        chk({nm, "_exibe"}, 32'(exibe_o), 0);
        chk({nm, "_busy"}, 32'(busy_o), 0);
        chk({nm, "_fin"}, 32'(fin_o), 0);
        chk({nm, "_abort"}, 32'(abort_o), 0);
        chk({nm, "_err"}, 32'(err_o), 0);
        chk({nm, "_count"}, 32'(fifo_count_o), 0);
        chk({nm, "_ready"}, 32'(cmd_ready), 1);
    endtask

    task automatic push(input logic [1:0] alg, input logic [1:0] zoom);
        cmd_valid = 1'b1;
        cmd_alg   = alg;
        cmd_zoom  = zoom;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Bounded wait for a start pulse or a completion pulse
    task automatic wait_evt(input string nm);
        int n = 0;
        while (start_o == 4'b0000 && !fin_o && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL %s_wait: got no start/fin within %0d cycles, required one", nm, n);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string nm = $sformatf("vec%0d", idx);
        start_log.delete();
        push(v.alg, v.zoom);
        wait_evt(nm);
        if (v.valid) begin
            chk({nm, "_start"}, 32'(start_o), 32'(4'b0001 << v.alg));
            chk_geo(nm, v.w, v.h, v.x, v.y);
            chk({nm, "_exibe0"}, 32'(exibe_o), 0);
            chk({nm, "_err"}, 32'(err_o), 0);
            tick();
            done_i = 4'b0001 << v.alg;
            tick();
            chk({nm, "_fin"}, 32'(fin_o), 1);
            chk({nm, "_exibe1"}, 32'(exibe_o), 1);
            chk({nm, "_busy"}, 32'(busy_o), 0);
            done_i = 4'b0000;
            exp_w = v.w; exp_h = v.h; exp_x = v.x; exp_y = v.y;
            tick();
            chk({nm, "_nstart"}, 32'(start_log.size()), 1);
        end else begin
            chk({nm, "_fin"}, 32'(fin_o), 1);
            chk({nm, "_err"}, 32'(err_o), 1);
            chk_geo(nm, exp_w, exp_h, exp_x, exp_y);
            chk({nm, "_exibe"}, 32'(exibe_o), 1);
            tick();
            chk({nm, "_nstart"}, 32'(start_log.size()), 0);
            chk({nm, "_busy"}, 32'(busy_o), 0);
        end
    endtask

    logic [1:0] fq_alg[6]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd3};
    logic [1:0] fq_zoom[6] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd0, 2'd0};

    initial begin
        vecs[0]  = '{2'd0, 2'd0, 1'b1, 160, 120, 240, 180};
        vecs[1]  = '{2'd0, 2'd1, 1'b1, 320, 240, 160, 120};
        vecs[2]  = '{2'd0, 2'd2, 1'b1, 640, 480,   0,   0};
        vecs[3]  = '{2'd0, 2'd3, 1'b0,   0,   0,   0,   0};
        vecs[4]  = '{2'd1, 2'd1, 1'b1,  80,  60, 280, 210};
        vecs[5]  = '{2'd1, 2'd2, 1'b1,  40,  30, 300, 225};
        vecs[6]  = '{2'd1, 2'd3, 1'b1,  20,  15, 310, 232};
        vecs[7]  = '{2'd2, 2'd1, 1'b1, 320, 240, 160, 120};
        vecs[8]  = '{2'd2, 2'd3, 1'b0,   0,   0,   0,   0};
        vecs[9]  = '{2'd3, 2'd2, 1'b1,  40,  30, 300, 225};
        vecs[10] = '{2'd3, 2'd0, 1'b1, 160, 120, 240, 180};
        vecs[11] = '{2'd2, 2'd2, 1'b1, 640, 480,   0,   0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_alg = 2'b00; cmd_zoom = 2'b00; done_i = 4'b0000;
        tick(); tick();
        chk_reset("rst");
        rst = 1'b0;
        tick(); tick();
        chk_reset("idle");

        // Latency: accept at edge 0, start during edge 2..3, done 50 cycles after start
        start_log.delete();
        cmd_valid = 1'b1; cmd_alg = 2'b00; cmd_zoom = 2'b01;
        tick();
        cmd_valid = 1'b0;
        chk("lat_e0_count", 32'(fifo_count_o), 1);
        chk("lat_e0_busy", 32'(busy_o), 0);
        tick();
        chk("lat_e1_busy", 32'(busy_o), 1);
        chk("lat_e1_start", 32'(start_o), 0);
        tick();
        chk("lat_e2_start", 32'(start_o), 1);
        chk_geo("lat_e2", 320, 240, 160, 120);
        chk("lat_e2_exibe", 32'(exibe_o), 0);
        chk("lat_e2_zoom", 32'(zoom_o), 1);
        tick();
        chk("lat_e3_start", 32'(start_o), 0);
        done_i = 4'b0100;
        repeat (10) tick();
        chk("lat_other_done_busy", 32'(busy_o), 1);
        chk("lat_other_done_fin", 32'(fin_o), 0);
        done_i = 4'b0000;
        repeat (39) tick();
        done_i = 4'b0001;
        tick();
        chk("lat_fin", 32'(fin_o), 1);
        chk("lat_exibe", 32'(exibe_o), 1);
        chk("lat_busy", 32'(busy_o), 0);
        tick();
        chk("lat_fin_pulse", 32'(fin_o), 0);
        chk("lat_exibe_hold", 32'(exibe_o), 1);
        chk("lat_nstart", 32'(start_log.size()), 1);
        done_i = 4'b0000;
        exp_w = 320; exp_h = 240; exp_x = 160; exp_y = 120;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Done held high before issue must not complete the run
        done_i = 4'b0010;
        tick(); tick();
        push(2'b01, 2'b11);
        wait_evt("stale");
        chk("stale_start", 32'(start_o), 2);
        repeat (6) tick();
        chk("stale_busy", 32'(busy_o), 1);
        chk("stale_fin0", 32'(fin_o), 0);
        done_i = 4'b0000;
        tick();
        chk("stale_busy_low", 32'(busy_o), 1);
        done_i = 4'b0010;
        tick();
        chk("stale_fin", 32'(fin_o), 1);
        chk_geo("stale", 20, 15, 310, 232);
        chk("stale_exibe", 32'(exibe_o), 1);
        done_i = 4'b0000;
        tick();

        // Fill the FIFO while the first command runs; extra push must be dropped
        start_log.delete();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("full_ready%0d", i), 32'(cmd_ready), 1);
            cmd_valid = 1'b1; cmd_alg = fq_alg[i]; cmd_zoom = fq_zoom[i];
            tick();
        end
        chk("full_count", 32'(fifo_count_o), 4);
        chk("full_ready", 32'(cmd_ready), 0);
        cmd_alg = fq_alg[5]; cmd_zoom = fq_zoom[5];
        tick(); tick();
        cmd_valid = 1'b0;
        chk("full_count_hold", 32'(fifo_count_o), 4);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                tick();
                wait_evt($sformatf("full%0d", i));
                tick();
            end
            chk($sformatf("full%0d_nstart", i), 32'(start_log.size()), i + 1);
            done_i = 4'b0001 << fq_alg[i];
            tick();
            chk($sformatf("full%0d_fin", i), 32'(fin_o), 1);
            chk($sformatf("full%0d_sel", i), 32'(sel_o), 32'(fq_alg[i]));
            chk($sformatf("full%0d_zoom", i), 32'(zoom_o), 32'(fq_zoom[i]));
            done_i = 4'b0000;
        end
        repeat (8) tick();
        chk("full_total_starts", 32'(start_log.size()), 5);
        for (int i = 0; i < 5 && i < start_log.size(); i++)
            chk($sformatf("full_order%0d", i), 32'(start_log[i]), 32'(4'b0001 << fq_alg[i]));
        chk("full_empty", 32'(fifo_count_o), 0);
        chk("full_idle", 32'(busy_o), 0);

        // Watchdog: 16 WAIT cycles without done
        push(2'b00, 2'b00);
        wait_evt("wd");
        repeat (16) tick();
        chk("wd_abort_early", 32'(abort_o), 0);
        chk("wd_busy_early", 32'(busy_o), 1);
        tick();
`ifdef CTRL_TIMEOUT_EN
        chk("wd_abort", 32'(abort_o), 1);
        chk("wd_err", 32'(err_o), 2);
        chk("wd_exibe", 32'(exibe_o), 0);
        chk("wd_busy", 32'(busy_o), 0);
        chk("wd_fin", 32'(fin_o), 0);
        tick();
        chk("wd_abort_pulse", 32'(abort_o), 0);
`else
        chk("wd_noabort", 32'(abort_o), 0);
        chk("wd_still_busy", 32'(busy_o), 1);
        repeat (20) tick();
        chk("wd_noabort_late", 32'(abort_o), 0);
        done_i = 4'b0001;
        tick();
        chk("wd_fin", 32'(fin_o), 1);
        done_i = 4'b0000;
        tick();
`endif

        // Reset in the middle of WAIT with a queued command
        push(2'b11, 2'b01);
        push(2'b00, 2'b01);
        wait_evt("mid");
        tick(); tick();
        chk("mid_busy", 32'(busy_o), 1);
        chk("mid_count", 32'(fifo_count_o), 1);
        chk_geo("mid", 80, 60, 280, 210);
        rst = 1'b1;
        start_log.delete();
        tick();
        chk_reset("midrst");
        rst = 1'b0;
        repeat (10) tick();
        chk("midrst_nstart", 32'(start_log.size()), 0);
        chk("midrst_idle", 32'(busy_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
